generic_reg_responder: RTL and testbench

Register-ring responder that sits in the user data path ring between the register master's request output and its reply input, alongside the pipeline stages. Each ring request is registered through in one cycle. A request whose tag matches this block and that no upstream block has claimed gets a response: a read or write of one of its hardware event counters or software control registers. All other traffic passes through unchanged. It is the slave-side endpoint that data-path modules instantiate to expose counters and control words to the host.

---
 rtl/generic_reg_responder_pkg.sv | 25 ++
 rtl/generic_reg_responder_if.sv | 18 +
 rtl/generic_reg_responder_reg_cntr_bank.sv | 50 +++++
 rtl/generic_reg_responder.sv | 140 ++++++++++++++
 tb/tb_generic_reg_responder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/generic_reg_responder_pkg.sv
// Shared definitions for the register-ring responder: ring field widths,
// the unmapped-read constant and the in-block offset decoder.
package generic_reg_responder_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  localparam logic [31:0] UNMAPPED_RD_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    REGION_CNTR = 2'd0,
    REGION_SW   = 2'd1,
    REGION_NONE = 2'd2
  } region_e;

  // Counters occupy the lowest offsets, software registers follow directly.
  function automatic region_e decode_region(input int unsigned off,
                                            input int unsigned n_cntrs,
                                            input int unsigned n_sw);
    if (off < n_cntrs)              return REGION_CNTR;
    else if (off < n_cntrs + n_sw)  return REGION_SW;
    else                            return REGION_NONE;
  endfunction

endpackage

// File: rtl/generic_reg_responder_if.sv
// One register-ring stage. reg_req marks a valid transfer for exactly one cycle;
// there is no ready, every stage accepts a transfer on every cycle.
interface generic_reg_responder_if #(
  parameter int SRC_W = 2
);
  import generic_reg_responder_pkg::*;

  logic                           reg_req;
  logic                           reg_ack;
  logic                           reg_rd_wr_L;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data;
  logic [SRC_W-1:0]               reg_src;

  modport master (output reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src);
  modport slave  (input  reg_req, reg_ack, reg_rd_wr_L, reg_addr, reg_data, reg_src);

endinterface

// File: rtl/generic_reg_responder_reg_cntr_bank.sv
// Bank of hardware event counters with per-counter increment, load,
// clear-on-read and a one-hot read mux returning a zero-extended value.
module generic_reg_responder_reg_cntr_bank #(
  parameter int NUM_CNTRS  = 4,
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CNTRS-1:0]  inc_i,
  input  logic [NUM_CNTRS-1:0]  load_i,
  input  logic [CNTR_WIDTH-1:0] load_data_i,
  input  logic [NUM_CNTRS-1:0]  clr_i,
  input  logic [NUM_CNTRS-1:0]  rd_sel_i,
  output logic [31:0]           rd_data_o
);

  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  logic [CNTR_WIDTH-1:0] cntr_q [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0] cntr_d [NUM_CNTRS];

  // A load beats a same-cycle increment; a clear still lets the increment land.
  always_comb begin
    for (int i = 0; i < NUM_CNTRS; i++) begin
      cntr_d[i] = cntr_q[i];
      if (load_i[i]) begin
        cntr_d[i] = load_data_i;
      end else begin
        if (clr_i[i]) cntr_d[i] = '0;
        if (inc_i[i]) cntr_d[i] = cntr_d[i] + ONE;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (rd_sel_i[i]) rd_data_o = rd_data_o | 32'(cntr_q[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNTRS; i++) cntr_q[i] <= '0;
    end else begin
      cntr_q <= cntr_d;
    end
  end

endmodule

// File: rtl/generic_reg_responder.sv
// Register-ring endpoint: answers unclaimed requests tagged for this block from
// its counters and software registers, forwards everything else one cycle later.
module generic_reg_responder
  import generic_reg_responder_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int NUM_CNTRS         = 4,
  parameter int NUM_SW_REGS       = 4,
  parameter int CNTR_WIDTH        = 32,
  parameter int RESET_ON_READ     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  generic_reg_responder_if.slave    reg_in,
  generic_reg_responder_if.master   reg_out,
  input  logic [NUM_CNTRS-1:0]      counter_updates,
  output logic [NUM_SW_REGS*32-1:0] software_regs
);

  localparam int TAG_W = UDP_REG_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [TAG_W-1:0] TAG_BITS = TAG_W'(TAG);

  logic [REG_ADDR_WIDTH-1:0] off;
  logic                      hit;
  region_e                   region;
  logic [NUM_CNTRS-1:0]      cntr_sel, cntr_load, cntr_clr;
  logic [NUM_SW_REGS-1:0]    sw_sel;
  logic [31:0]               cntr_rd_data, sw_rd_data;
  logic [31:0]               sw_q [NUM_SW_REGS];
  logic [31:0]               sw_d [NUM_SW_REGS];

  logic                           req_q, req_d, ack_q, ack_d, rd_wr_L_q, rd_wr_L_d;
  logic [UDP_REG_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CPCI_NF2_DATA_WIDTH-1:0] data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]   src_q, src_d;

  assign off    = reg_in.reg_addr[REG_ADDR_WIDTH-1:0];
  assign hit    = reg_in.reg_req & ~reg_in.reg_ack &
                  (reg_in.reg_addr[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == TAG_BITS);
  assign region = decode_region(32'(off), NUM_CNTRS, NUM_SW_REGS);

  always_comb begin
    for (int i = 0; i < NUM_CNTRS; i++)   cntr_sel[i] = (32'(off) == 32'(i));
    for (int k = 0; k < NUM_SW_REGS; k++) sw_sel[k]   = (32'(off) == 32'(NUM_CNTRS + k));
  end

  always_comb begin
    sw_rd_data = '0;
    for (int k = 0; k < NUM_SW_REGS; k++) begin
      if (sw_sel[k]) sw_rd_data = sw_rd_data | sw_q[k];
    end
  end

  generic_reg_responder_reg_cntr_bank #(
    .NUM_CNTRS  (NUM_CNTRS),
    .CNTR_WIDTH (CNTR_WIDTH)
  ) u_cntr_bank (
    .clk         (clk),
    .reset       (reset),
    .inc_i       (counter_updates),
    .load_i      (cntr_load),
    .load_data_i (reg_in.reg_data[CNTR_WIDTH-1:0]),
    .clr_i       (cntr_clr),
    .rd_sel_i    (cntr_sel),
    .rd_data_o   (cntr_rd_data)
  );

  always_comb begin
    req_d     = reg_in.reg_req;
    ack_d     = reg_in.reg_ack;
    rd_wr_L_d = reg_in.reg_rd_wr_L;
    addr_d    = reg_in.reg_addr;
    data_d    = reg_in.reg_data;
    src_d     = reg_in.reg_src;
    cntr_load = '0;
    cntr_clr  = '0;
    sw_d      = sw_q;
    if (!reg_in.reg_req) begin
      ack_d = 1'b0;
    end else if (hit) begin
      ack_d = 1'b1;
      case (region)
        REGION_CNTR: begin
          if (reg_in.reg_rd_wr_L) begin
            data_d = cntr_rd_data;
            if (RESET_ON_READ != 0) cntr_clr = cntr_sel;
          end else begin
            cntr_load = cntr_sel;
          end
        end
        REGION_SW: begin
          if (reg_in.reg_rd_wr_L) begin
            data_d = sw_rd_data;
          end else begin
            for (int k = 0; k < NUM_SW_REGS; k++) begin
              if (sw_sel[k]) sw_d[k] = reg_in.reg_data;
            end
          end
        end
        default: begin
          if (reg_in.reg_rd_wr_L) data_d = UNMAPPED_RD_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      rd_wr_L_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
      for (int k = 0; k < NUM_SW_REGS; k++) sw_q[k] <= '0;
    end else begin
      req_q     <= req_d;
      ack_q     <= ack_d;
      rd_wr_L_q <= rd_wr_L_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
      sw_q      <= sw_d;
    end
  end

  assign reg_out.reg_req     = req_q;
  assign reg_out.reg_ack     = ack_q;
  assign reg_out.reg_rd_wr_L = rd_wr_L_q;
  assign reg_out.reg_addr    = addr_q;
  assign reg_out.reg_data    = data_q;
  assign reg_out.reg_src     = src_q;

  for (genvar k = 0; k < NUM_SW_REGS; k++) begin : g_sw_out
    assign software_regs[32*k +: 32] = sw_q[k];
  end

endmodule

// File: tb/tb_generic_reg_responder.sv
// Bench for generic_reg_responder: two instances (plain 32-bit counters, and
// 8-bit clear-on-read counters) share one input ring and are checked each cycle.
module tb_generic_reg_responder;

  logic         clk;
  logic         rst_n;
  logic [3:0]   upd;
  logic [127:0] sw0, sw1;

  int checks = 0;
  int errors = 0;

  generic_reg_responder_if #(.SRC_W(2)) ring_in ();
  generic_reg_responder_if #(.SRC_W(2)) ring_out0 ();
  generic_reg_responder_if #(.SRC_W(2)) ring_out1 ();

  generic_reg_responder #(
    .UDP_REG_SRC_WIDTH(2), .TAG(3), .REG_ADDR_WIDTH(5), .NUM_CNTRS(4),
    .NUM_SW_REGS(4), .CNTR_WIDTH(32), .RESET_ON_READ(0)
  ) dut0 (
    .clk(clk), .reset(rst_n), .reg_in(ring_in), .reg_out(ring_out0),
    .counter_updates(upd), .software_regs(sw0)
  );

  generic_reg_responder #(
    .UDP_REG_SRC_WIDTH(2), .TAG(3), .REG_ADDR_WIDTH(5), .NUM_CNTRS(4),
    .NUM_SW_REGS(4), .CNTR_WIDTH(8), .RESET_ON_READ(1)
  ) dut1 (
    .clk(clk), .reset(rst_n), .reg_in(ring_in), .reg_out(ring_out1),
    .counter_updates(upd), .software_regs(sw1)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  logic [31:0] m_cnt [2][4];
  logic [31:0] m_sw  [2][4];
  logic        exp_req [2], exp_ack [2], exp_rw [2];
  logic [22:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [1:0]  exp_src [2];

  task automatic model_step(input int p);
    logic [31:0] mask;
    bit          ror, hit, rd;
    int          off;
    bit          wrote [4];
    mask = (p == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    ror  = (p == 1);
    off  = int'(ring_in.reg_addr[4:0]);
    rd   = ring_in.reg_rd_wr_L;
    hit  = ring_in.reg_req && !ring_in.reg_ack && (ring_in.reg_addr[22:5] == 18'd3);
    for (int i = 0; i < 4; i++) wrote[i] = 1'b0;
    exp_req[p]  = ring_in.reg_req;
    exp_rw[p]   = rd;
    exp_addr[p] = ring_in.reg_addr;
    exp_src[p]  = ring_in.reg_src;
    exp_data[p] = ring_in.reg_data;
    exp_ack[p]  = ring_in.reg_req ? ring_in.reg_ack : 1'b0;
    if (hit) begin
      exp_ack[p] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (off == i) begin
          if (rd) begin
            exp_data[p] = m_cnt[p][i];
            if (ror) m_cnt[p][i] = 32'd0;
          end else begin
            m_cnt[p][i] = ring_in.reg_data & mask;
            wrote[i]    = 1'b1;
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (off == 4 + k) begin
          if (rd) exp_data[p] = m_sw[p][k];
          else    m_sw[p][k]  = ring_in.reg_data;
        end
      end
      if (off >= 8 && rd) exp_data[p] = 32'hDEAD_BEEF;
    end
    for (int i = 0; i < 4; i++) begin
      if (upd[i] && !wrote[i]) m_cnt[p][i] = (m_cnt[p][i] + 32'd1) & mask;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 4; i++) begin
          m_cnt[p][i] = 32'd0;
          m_sw[p][i]  = 32'd0;
        end
        exp_req[p] = 1'b0; exp_ack[p] = 1'b0; exp_rw[p] = 1'b0;
        exp_addr[p] = '0; exp_data[p] = '0; exp_src[p] = '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) model_step(p);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int p, input logic req, input logic ack, input logic rw,
                         input logic [22:0] addr, input logic [31:0] data,
                         input logic [1:0] src, input logic [127:0] sw);
    string tag;
    tag = (p == 0) ? "dut0" : "dut1";
    chk({tag, ".req"},  32'(req),  32'(exp_req[p]));
    chk({tag, ".ack"},  32'(ack),  32'(exp_ack[p]));
    chk({tag, ".rw"},   32'(rw),   32'(exp_rw[p]));
    chk({tag, ".addr"}, 32'(addr), 32'(exp_addr[p]));
    chk({tag, ".data"}, data,      exp_data[p]);
    chk({tag, ".src"},  32'(src),  32'(exp_src[p]));
    for (int k = 0; k < 4; k++) chk({tag, ".sw"}, sw[32*k +: 32], m_sw[p][k]);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, ring_out0.reg_req, ring_out0.reg_ack, ring_out0.reg_rd_wr_L,
            ring_out0.reg_addr, ring_out0.reg_data, ring_out0.reg_src, sw0);
    cmp_dut(1, ring_out1.reg_req, ring_out1.reg_ack, ring_out1.reg_rd_wr_L,
            ring_out1.reg_addr, ring_out1.reg_data, ring_out1.reg_src, sw1);
  end

  // ---------------- driver ----------------
  task automatic set_in(input bit req, input bit ack, input bit rd, input int tag,
                        input int off, input logic [31:0] data, input logic [1:0] src,
                        input logic [3:0] u);
    ring_in.reg_req     = req;
    ring_in.reg_ack     = ack;
    ring_in.reg_rd_wr_L = rd;
    ring_in.reg_addr    = {18'(tag), 5'(off)};
    ring_in.reg_data    = data;
    ring_in.reg_src     = src;
    upd                 = u;
  endtask

  task automatic cyc(input bit req, input bit ack, input bit rd, input int tag,
                     input int off, input logic [31:0] data, input logic [1:0] src,
                     input logic [3:0] u);
    set_in(req, ack, rd, tag, off, data, src, u);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [3:0] u);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'd0, 2'd0, u);
  endtask

  // Moves from 2 after the sampling edge to the following falling edge.
  task automatic to_out();
    #3;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 32'd0, 2'd0, 4'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.req0",  32'(ring_out0.reg_req), 32'd0);
    chk("rst.ack0",  32'(ring_out0.reg_ack), 32'd0);
    chk("rst.data1", ring_out1.reg_data,     32'd0);
    repeat (2) @(posedge clk);
    #2;
    set_in(0, 0, 0, 0, 0, 32'd0, 2'd0, 4'h0);
    rst_n = 1'b1;
    idle(1, 4'h0);

    // five increments of counter 0, then read it
    idle(5, 4'h1);
    cyc(1, 0, 1, 3, 0, 32'h0, 2'd2, 4'h0);
    to_out();
    chk("cnt0.data0", ring_out0.reg_data, 32'd5);
    chk("cnt0.data1", ring_out1.reg_data, 32'd5);
    chk("cnt0.ack0",  32'(ring_out0.reg_ack),  32'd1);
    chk("cnt0.addr0", 32'(ring_out0.reg_addr), 32'h60);
    chk("cnt0.src0",  32'(ring_out0.reg_src),  32'd2);

    // software register write then read back
    cyc(1, 0, 0, 3, 4, 32'h1234_5678, 2'd1, 4'h0);
    to_out();
    chk("sw.wr",     sw0[31:0], 32'h1234_5678);
    cyc(1, 0, 1, 3, 4, 32'h0, 2'd1, 4'h0);
    to_out();
    chk("sw.rd",     ring_out0.reg_data, 32'h1234_5678);
    chk("sw.rd.ack", 32'(ring_out0.reg_ack), 32'd1);

    // foreign tag, and claimed request, pass through untouched
    cyc(1, 0, 0, 2, 4, 32'hCAFE_0001, 2'd3, 4'h0);
    to_out();
    chk("pass.data", ring_out0.reg_data, 32'hCAFE_0001);
    chk("pass.ack",  32'(ring_out0.reg_ack),  32'd0);
    chk("pass.addr", 32'(ring_out0.reg_addr), 32'h44);
    cyc(1, 1, 0, 3, 4, 32'hA5A5_A5A5, 2'd0, 4'h0);
    to_out();
    chk("claimed.ack",  32'(ring_out0.reg_ack), 32'd1);
    chk("claimed.data", ring_out0.reg_data,     32'hA5A5_A5A5);
    chk("claimed.sw",   sw0[31:0],              32'h1234_5678);

    // read concurrent with increment, with and without clear-on-read
    cyc(1, 0, 0, 3, 1, 32'd7, 2'd0, 4'h0);
    cyc(1, 0, 1, 3, 1, 32'd0, 2'd0, 4'h2);
    to_out();
    chk("ror.first0", ring_out0.reg_data, 32'd7);
    chk("ror.first1", ring_out1.reg_data, 32'd7);
    cyc(1, 0, 1, 3, 1, 32'd0, 2'd0, 4'h0);
    to_out();
    chk("ror.second0", ring_out0.reg_data, 32'd8);
    chk("ror.second1", ring_out1.reg_data, 32'd1);

    // wrap of the 8-bit counter
    cyc(1, 0, 0, 3, 2, 32'd255, 2'd0, 4'h0);
    idle(1, 4'h4);
    cyc(1, 0, 1, 3, 2, 32'd0, 2'd0, 4'h0);
    to_out();
    chk("wrap0", ring_out0.reg_data, 32'd256);
    chk("wrap1", ring_out1.reg_data, 32'd0);

    // write beats a same-cycle increment
    cyc(1, 0, 0, 3, 3, 32'd10, 2'd0, 4'h8);
    cyc(1, 0, 1, 3, 3, 32'd0, 2'd0, 4'h0);
    to_out();
    chk("wr_inc0", ring_out0.reg_data, 32'd10);
    chk("wr_inc1", ring_out1.reg_data, 32'd10);

    // unmapped offset
    cyc(1, 0, 1, 3, 31, 32'h0, 2'd1, 4'h0);
    to_out();
    chk("unmapped.data", ring_out0.reg_data, 32'hDEAD_BEEF);
    chk("unmapped.ack",  32'(ring_out0.reg_ack), 32'd1);
    cyc(1, 0, 0, 3, 20, 32'h5555_5555, 2'd1, 4'h0);

    // four back-to-back reads, one ack per cycle
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 3, i, 32'h0, 2'(i), 4'h5);
      to_out();
      chk("b2b.ack", 32'(ring_out0.reg_ack), 32'd1);
    end

    // remaining software registers and idle data copying
    cyc(1, 0, 0, 3, 5, 32'hFEED_0005, 2'd2, 4'h0);
    cyc(1, 0, 0, 3, 7, 32'h0BAD_0007, 2'd3, 4'h0);
    cyc(0, 0, 1, 3, 6, 32'h7777_0000, 2'd1, 4'h0);
    cyc(1, 0, 1, 3, 7, 32'h0, 2'd0, 4'h0);
    to_out();
    chk("sw7.rd", ring_out0.reg_data, 32'h0BAD_0007);
    cyc(1, 0, 1, 3, 6, 32'h0, 2'd0, 4'h0);
    idle(2, 4'h0);

    // reset while a hit write is on the ring
    set_in(1, 0, 0, 3, 5, 32'hFFFF_FFFF, 2'd3, 4'hF);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst.req0", 32'(ring_out0.reg_req), 32'd0);
    chk("midrst.ack0", 32'(ring_out0.reg_ack), 32'd0);
    chk("midrst.sw0",  sw0[31:0],   32'd0);
    chk("midrst.sw1",  sw1[63:32],  32'd0);
    repeat (2) @(posedge clk);
    #2;
    set_in(0, 0, 0, 0, 0, 32'd0, 2'd0, 4'h0);
    rst_n = 1'b1;
    idle(1, 4'h0);
    to_out();
    chk("postrst.ack0", 32'(ring_out0.reg_ack), 32'd0);
    cyc(1, 0, 1, 3, 0, 32'h0, 2'd0, 4'h0);
    to_out();
    chk("postrst.cnt0", ring_out0.reg_data, 32'd0);
    cyc(1, 0, 1, 3, 5, 32'h0, 2'd0, 4'h0);
    to_out();
    chk("postrst.sw5", ring_out0.reg_data, 32'd0);
    idle(2, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
